// File: rtl/rr_grant_scheduler.sv
// -----------------------------------------------------------------------------
// rr_grant_scheduler
//
// Round-robin owner of a single 32-way shared resource. Picks one requester,
// holds the grant until the owner releases it (done pulse or request drop),
// then rotates priority to the requester just after the released owner.
// gnt_idx_o drives the select of the downstream 5-to-32 decoder. All outputs
// are registered; there is no combinational path from inputs to outputs.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   : a hold counter forces release after MAX_HOLD grant cycles and
//               pulses timeout_o for one cycle on the forced release.
//   undefined : no counter logic, grants are held until released, and
//               timeout_o is tied low.
//
// Parameters
//   MAX_HOLD     maximum grant length in cycles (2..65535), used only with
//                ARB_TIMEOUT_EN.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-high reset
//   req_i[31:0]  level-sensitive request vector, bit i = requester i
//   done_i       release pulse from the current owner (ignored when idle)
//   gnt_o[31:0]  registered one-hot grant, zero when idle
//   gnt_idx_o    registered index of the granted requester (decoder select);
//                keeps its last value while idle
//   gnt_valid_o  registered, high while a grant is active (OR of gnt_o)
//   timeout_o    one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module rr_grant_scheduler #(
  parameter int MAX_HOLD = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] req_i,
  input  logic        done_i,
  output logic [31:0] gnt_o,
  output logic [4:0]  gnt_idx_o,
  output logic        gnt_valid_o,
  output logic        timeout_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Reject an out-of-range hold limit at elaboration.
  if ((MAX_HOLD < 2) || (MAX_HOLD > 65535)) begin : g_bad_max_hold
    $error("rr_grant_scheduler: MAX_HOLD must be within 2..65535");
  end

  // First set bit of req searching ptr, ptr+1, ..., wrapping modulo 32.
  // Only meaningful when req is non-zero.
  function automatic logic [4:0] rr_pick(input logic [31:0] req,
                                         input logic [4:0]  ptr);
    logic [4:0] pick;
    logic [4:0] idx;
    logic       found;
    pick  = 5'd0;
    found = 1'b0;
    for (int k = 0; k < 32; k++) begin
      idx = ptr + 5'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] gnt_q, gnt_d;
  logic [4:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic [4:0]  ptr_q, ptr_d;

  logic        any_req_s;
  logic [4:0]  winner_s;
  logic        norm_rel_s;
  logic        forced_s;
  logic        release_s;

  assign any_req_s  = |req_i;
  assign winner_s   = rr_pick(req_i, ptr_q);
  // Owner-driven release: explicit done or the owner dropping its request.
  assign norm_rel_s = done_i | ~req_i[idx_q];
  assign release_s  = norm_rel_s | forced_s;

`ifdef ARB_TIMEOUT_EN
  localparam int            CW        = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  logic [CW-1:0] hold_q, hold_d;
  logic          timeout_q, timeout_d;

  // The last permitted grant cycle has been reached.
  assign forced_s = (state_q == ST_BUSY) && (hold_q == HOLD_LAST);

  // Hold counter and timeout pulse; a normal release on the limit edge wins.
  always_comb begin
    hold_d    = hold_q;
    timeout_d = 1'b0;
    if (state_q == ST_BUSY) begin
      if (release_s) begin
        hold_d = {CW{1'b0}};
      end else begin
        hold_d = hold_q + CW'(1);
      end
      timeout_d = forced_s & ~norm_rel_s;
    end else begin
      hold_d = {CW{1'b0}};
    end
  end

  // Hold counter and timeout registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q    <= {CW{1'b0}};
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign forced_s  = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Next-state and registered-output computation for the grant FSM.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          state_d = ST_BUSY;
          gnt_d   = 32'h0000_0001 << winner_s;
          idx_d   = winner_s;
          valid_d = 1'b1;
        end else begin
          gnt_d   = 32'h0000_0000;
          valid_d = 1'b0;
        end
      end
      ST_BUSY: begin
        // Other requesters are ignored here: no preemption.
        if (release_s) begin
          state_d = ST_IDLE;
          gnt_d   = 32'h0000_0000;
          valid_d = 1'b0;
          ptr_d   = idx_q + 5'd1;   // 31 wraps to 0
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 32'h0000_0000;
        valid_d = 1'b0;
      end
    endcase
  end

  // FSM state, grant outputs and rotation pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= 32'h0000_0000;
      idx_q   <= 5'd0;
      valid_q <= 1'b0;
      ptr_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = idx_q;
  assign gnt_valid_o = valid_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rr_grant_scheduler
//
// Self-checking bench for rr_grant_scheduler. Each applied vector pushes its
// expected post-edge outputs onto a scoreboard queue; after the clock edge the
// entry is popped and compared with the DUT outputs. A table of vectors covers
// the basic round-robin behaviour; hand-written sequences cover the hold limit
// (ARB_TIMEOUT_EN builds) or indefinite hold (default build), asynchronous
// reset in the middle of a grant, and a full 32-way rotation.
// -----------------------------------------------------------------------------
module tb_rr_grant_scheduler;

  typedef struct packed {
    logic [31:0] req;
    logic        done;
    logic        exp_valid;
    logic [4:0]  exp_idx;
    logic        exp_to;
  } vec_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] idx;
    logic       to;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req;
  logic        done;
  logic [31:0] gnt;
  logic [4:0]  gnt_idx;
  logic        gnt_valid;
  logic        timeout;

  int checks = 0;
  int fails  = 0;

  exp_t  exp_q[$];
  string name_q[$];
  vec_t  vecs[$];

  rr_grant_scheduler #(.MAX_HOLD(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .done_i      (done),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid),
    .timeout_o   (timeout)
  );

  always #5 clk = ~clk;

  // Compare DUT outputs against the oldest scoreboard entry.
  task automatic check_out();
    exp_t        e;
    string       nm;
    logic [31:0] exp_gnt;
    checks++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard: no expected entry, got gnt=%h", gnt);
    end else begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      exp_gnt = e.valid ? (32'h0000_0001 << e.idx) : 32'h0000_0000;
      if (gnt !== exp_gnt || gnt_idx !== e.idx || gnt_valid !== e.valid ||
          timeout !== e.to) begin
        fails++;
        $display("FAIL %s: got gnt=%h idx=%0d valid=%b to=%b, expected gnt=%h idx=%0d valid=%b to=%b",
                 nm, gnt, gnt_idx, gnt_valid, timeout, exp_gnt, e.idx, e.valid, e.to);
      end
    end
    // Structural invariant: zero or one-hot, and gnt[gnt_idx] == gnt_valid.
    checks++;
    if (!$onehot0(gnt) || (gnt[gnt_idx] !== gnt_valid)) begin
      fails++;
      $display("FAIL invariant: got gnt=%h idx=%0d valid=%b, expected one-hot with gnt[idx]==valid",
               gnt, gnt_idx, gnt_valid);
    end
  endtask

  // Drive one vector, record its expectation, clock, then compare.
  task automatic apply(input vec_t v, input string nm);
    exp_t e;
    req  = v.req;
    done = v.done;
    e.valid = v.exp_valid;
    e.idx   = v.exp_idx;
    e.to    = v.exp_to;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    check_out();
  endtask

  function automatic void add(input logic [31:0] r, input logic d,
                              input logic v, input logic [4:0] i,
                              input logic t);
    vec_t x;
    x.req = r; x.done = d; x.exp_valid = v; x.exp_idx = i; x.exp_to = t;
    vecs.push_back(x);
  endfunction

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r2;
    logic [31:0] r4;
    logic [4:0]  w;

    rst  = 1'b1;
    req  = 32'h0000_0000;
    done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (gnt !== 32'h0000_0000 || gnt_idx !== 5'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got gnt=%h idx=%0d valid=%b to=%b, expected all zero",
               gnt, gnt_idx, gnt_valid, timeout);
    end
    rst = 1'b0;

    // ---- table: basic grant/release, pointer advance, 31->0 wrap --------
    add(32'h0000_0001, 1'b0, 1'b1, 5'd0,  1'b0);  // grant 0
    add(32'h0000_0001, 1'b1, 1'b0, 5'd0,  1'b0);  // done -> release, ptr=1
    add(32'h0000_0000, 1'b0, 1'b0, 5'd0,  1'b0);  // idle, idx held
    add(32'h0000_0003, 1'b0, 1'b1, 5'd1,  1'b0);  // ptr=1 prefers 1 over 0
    add(32'h0000_0003, 1'b1, 1'b0, 5'd1,  1'b0);  // release, ptr=2
    r2 = 32'h8000_0001;
    for (int g = 0; g < 4; g++) begin
      w = (g % 2 == 0) ? 5'd31 : 5'd0;
      add(r2, 1'b0, 1'b1, w, 1'b0);
      add(r2, 1'b0, 1'b1, w, 1'b0);
      add(r2, 1'b1, 1'b0, w, 1'b0);
    end
    // ptr=1: owner 5, no preemption, release by req drop, then 9, then 3.
    r4 = 32'h0000_0208;                            // bits 9 and 3
    add(32'h0000_0020, 1'b0, 1'b1, 5'd5,  1'b0);
    add(32'h0000_0228, 1'b0, 1'b1, 5'd5,  1'b0);
    add(r4,            1'b0, 1'b0, 5'd5,  1'b0);  // req[5] dropped
    add(r4,            1'b0, 1'b1, 5'd9,  1'b0);
    add(r4,            1'b1, 1'b0, 5'd9,  1'b0);
    add(r4,            1'b0, 1'b1, 5'd3,  1'b0);
    add(r4,            1'b1, 1'b0, 5'd3,  1'b0);  // ptr=4
    add(32'h0000_0000, 1'b1, 1'b0, 5'd3,  1'b0);  // done in idle: no effect
    add(32'h0000_0000, 1'b0, 1'b0, 5'd3,  1'b0);
    add(32'h0010_0000, 1'b0, 1'b1, 5'd20, 1'b0);
    add(32'h0000_0000, 1'b1, 1'b0, 5'd20, 1'b0);  // done + req drop together
    add(32'h0030_0000, 1'b0, 1'b1, 5'd21, 1'b0);  // single advance: ptr=21
    add(32'h0000_0000, 1'b0, 1'b0, 5'd21, 1'b0);  // ptr=22

    foreach (vecs[i]) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

`ifdef ARB_TIMEOUT_EN
    // ---- hold limit 4: forced release, then normal release on limit edge -
    apply({32'h0000_0280, 1'b0, 1'b1, 5'd7, 1'b0}, "to_grant7");
    for (int c = 0; c < 3; c++) begin
      apply({32'h0000_0280, 1'b0, 1'b1, 5'd7, 1'b0}, $sformatf("to_hold%0d", c));
    end
    apply({32'h0000_0280, 1'b0, 1'b0, 5'd7, 1'b1}, "to_forced");
    apply({32'h0000_0280, 1'b0, 1'b1, 5'd9, 1'b0}, "to_next9");
    for (int c = 0; c < 3; c++) begin
      apply({32'h0000_0280, 1'b0, 1'b1, 5'd9, 1'b0}, $sformatf("to_hold9_%0d", c));
    end
    apply({32'h0000_0280, 1'b1, 1'b0, 5'd9, 1'b0}, "to_done_on_limit");
`else
    // ---- no limit: grant persists until released ------------------------
    apply({32'h0000_0280, 1'b0, 1'b1, 5'd7, 1'b0}, "hold_grant7");
    for (int c = 0; c < 10; c++) begin
      apply({32'h0000_0280, 1'b0, 1'b1, 5'd7, 1'b0}, $sformatf("hold7_%0d", c));
    end
    apply({32'h0000_0280, 1'b1, 1'b0, 5'd7, 1'b0}, "hold_release7");
`endif

    // ---- asynchronous reset in the middle of a grant ---------------------
    apply({32'h0000_1000, 1'b0, 1'b1, 5'd12, 1'b0}, "grant12");
    rst = 1'b1;
    #1;
    checks++;
    if (gnt !== 32'h0000_0000 || gnt_idx !== 5'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got gnt=%h idx=%0d valid=%b to=%b, expected all zero",
               gnt, gnt_idx, gnt_valid, timeout);
    end
    req = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ---- full rotation: 0, 1, ..., 31, 0 --------------------------------
    for (int k = 0; k < 33; k++) begin
      w = 5'(k % 32);
      apply({32'hFFFF_FFFF, 1'b0, 1'b1, w, 1'b0}, $sformatf("rot_grant%0d", k));
      apply({32'hFFFF_FFFF, 1'b1, 1'b0, w, 1'b0}, $sformatf("rot_rel%0d", k));
    end

    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rr_grant_scheduler.md
# rr_grant_scheduler

Round-robin scheduler that shares one 32-way resource among 32 requesters and drives the 5-bit select of the 5-to-32 decoder that enables it. It owns the grant lifetime: it picks a winner, holds the grant until the owner releases it, then rotates priority. Outputs are registered, so the decoder stage sees a stable select one cycle after arbitration.

## Interface
- MAX_HOLD, 64: maximum grant length in cycles; effective only when the timeout feature is compiled in; legal range 2..65535.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  32  request vector; bit i is requester i; level-sensitive.
- done  input  1  release pulse from the current owner; ignored when no grant is active.
- gnt  output  32  registered one-hot grant; all zero when idle.
- gnt_idx  output  5  registered index of the granted requester; feeds the decoder select.
- gnt_valid  output  1  high while a grant is active; equals OR of gnt.
- timeout  output  1  one-cycle pulse on forced release.

## Operation
- Two states: IDLE, BUSY. Reset state IDLE.
- Reset values: gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, rotation pointer ptr=0, hold counter=0.
- IDLE: if req!=0, the winner is the first set bit searching ptr, ptr+1, ..., 31, 0, ..., ptr-1 (mod 32). Register gnt=1<<winner, gnt_idx=winner, gnt_valid=1, clear hold counter, go BUSY. If req==0, stay IDLE with outputs zero.
- BUSY: release when done=1 or req[gnt_idx]=0. On release: gnt=0, gnt_valid=0, ptr=(gnt_idx+1) mod 32 (5-bit wrap, 31 -> 0), go IDLE. gnt_idx keeps its last value while idle.
- Other requesters' req bits are ignored in BUSY; no preemption.
- done and req drop in the same cycle: a single release.
- done asserted in IDLE: no effect.
- Invariant: gnt is zero or exactly one-hot, and gnt[gnt_idx]=gnt_valid.

## Timing
- Arbitration latency: req sampled in IDLE at edge N -> gnt/gnt_idx/gnt_valid valid after edge N.
- Release latency: done or req drop sampled at edge M -> gnt low after edge M.
- Mandatory one idle cycle between grants; the next winner is decided at edge M+1 and visible after it. Maximum rate: one grant per hold+1 cycles.
- Asynchronous reset mid-grant: all outputs zero immediately, ptr returns to 0, and the interrupted requester gets no priority retention.
- Combinational paths from inputs to outputs: none.

## Configuration
- ARB_TIMEOUT_EN defined: the hold counter increments every BUSY cycle. The grant is visible for at most MAX_HOLD cycles. If the counter is MAX_HOLD-1 and no release occurs, a forced release follows the normal release path (ptr advances past the owner) and timeout=1 for that one cycle. Normal release on the same edge takes precedence, with timeout=0. The counter width is $clog2(MAX_HOLD).
- ARB_TIMEOUT_EN undefined: no counter logic; a grant is held indefinitely until release; timeout is tied to 0.

## Test plan
- Reset, then req=32'h0000_0001 -> after one edge gnt=32'h1, gnt_idx=0, gnt_valid=1. Then done pulse -> gnt=0 on the next cycle, ptr=1.
- req=32'h8000_0001 held with the owner pulsing done after 2 grant cycles -> grant order 0, 31, 0, 31, each separated by one idle cycle. Covers the 31 -> 0 wrap.
- req=32'hFFFF_FFFF, done every grant -> gnt_idx sequence 0, 1, 2, ..., 31, 0. Never two bits of gnt set.
- Owner 5 granted, req[5] drops while req[9] and req[3] are high -> release after one edge, then gnt_idx=9, then 3 in the next rounds.
- ARB_TIMEOUT_EN with MAX_HOLD=4, req[7] held, done never -> gnt[7] high exactly 4 cycles, timeout=1 on the forced-release edge, next grant skips to another requester if any.
- Assert rst mid-BUSY (gnt_idx=12) -> outputs zero asynchronously. After deassert with req=32'hFFFF_FFFF -> gnt_idx=0.
